// File: rtl/cv32e40x_bch_predictor_if.sv
// rtl/cv32e40x_bch_predictor_if.sv - target-select type and ID/EX bundle for the branch predictor
package cv32e40x_bch_pkg;
   typedef enum logic [1:0] {
      CT_JAL  = 2'd0,
      CT_BCH  = 2'd1,
      CT_JALR = 2'd2
   } bch_jmp_mux_e;
endpackage

interface cv32e40x_bch_predictor_if;
   import cv32e40x_bch_pkg::*;

   bch_jmp_mux_e bch_jmp_mux_sel_i;
   logic [31:0]  pc_id_i;
   logic [31:0]  imm_uj_type_i;
   logic [31:0]  imm_sb_type_i;
   logic [31:0]  imm_i_type_i;
   logic [31:0]  jalr_fw_i;
   logic         id_bch_i;
   logic         id_ex_hs_i;
   logic         ex_flush_i;
   logic         ex_resolve_i;
   logic         ex_taken_i;
   logic [31:0]  bch_target_o;
   logic [31:0]  jmp_target_o;
   logic         bch_prediction_id_o;
   logic         ex_pred_valid_o;
   logic         ex_pred_taken_o;
   logic         ex_mispredict_o;

   // pipeline side: drives ID/EX status, consumes targets and predictions
   modport master (
      output bch_jmp_mux_sel_i, pc_id_i, imm_uj_type_i, imm_sb_type_i, imm_i_type_i,
             jalr_fw_i, id_bch_i, id_ex_hs_i, ex_flush_i, ex_resolve_i, ex_taken_i,
      input  bch_target_o, jmp_target_o, bch_prediction_id_o,
             ex_pred_valid_o, ex_pred_taken_o, ex_mispredict_o
   );

   // predictor side
   modport slave (
      input  bch_jmp_mux_sel_i, pc_id_i, imm_uj_type_i, imm_sb_type_i, imm_i_type_i,
             jalr_fw_i, id_bch_i, id_ex_hs_i, ex_flush_i, ex_resolve_i, ex_taken_i,
      output bch_target_o, jmp_target_o, bch_prediction_id_o,
             ex_pred_valid_o, ex_pred_taken_o, ex_mispredict_o
   );
endinterface

// File: rtl/cv32e40x_bch_predictor.sv
// rtl/cv32e40x_bch_predictor.sv - ID-stage jump/branch target unit with counter-table branch predictor
module cv32e40x_bch_predictor
   import cv32e40x_bch_pkg::*;
#(
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 2,
   parameter int PRED_MODE = 1
) (
   input logic clk,
   input logic rst_n,
   cv32e40x_bch_predictor_if.slave bus
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [31:0]      target;
   logic [IDX_W-1:0] id_idx;
   logic             table_pred;
   logic             ex_valid;
   logic             ex_pred;
   logic [IDX_W-1:0] ex_idx;
   logic             train;

   // target adder: one shared result drives both target outputs
   always_comb begin
      target = bus.jalr_fw_i + bus.imm_i_type_i;
      case (bus.bch_jmp_mux_sel_i)
         CT_JAL:  target = bus.pc_id_i + bus.imm_uj_type_i;
         CT_BCH:  target = bus.pc_id_i + bus.imm_sb_type_i;
         default: target = bus.jalr_fw_i + bus.imm_i_type_i;
      endcase
   end

   assign bus.bch_target_o = target;
   assign bus.jmp_target_o = target;

   // halfword-granular index so compressed instructions get their own entries
   assign id_idx = bus.pc_id_i[IDX_W:1];

   // only a live, unflushed tracked branch may update the table
   assign train = bus.ex_resolve_i & ex_valid & ~bus.ex_flush_i;

   generate
      if (PRED_MODE == 1) begin : g_dyn
         localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);
         localparam logic [CNT_W-1:0] CNT_MAX = '1;
         localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

         logic [CNT_W-1:0] cnt [BHT_DEPTH];

         // saturating counter update; ID reads the pre-edge value on a same-entry collision
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < BHT_DEPTH; i++) begin
                  cnt[i] <= CNT_RST;
               end
            end else if (train) begin
               if (bus.ex_taken_i) begin
                  if (cnt[ex_idx] != CNT_MAX) cnt[ex_idx] <= cnt[ex_idx] + CNT_ONE;
               end else begin
                  if (cnt[ex_idx] != '0) cnt[ex_idx] <= cnt[ex_idx] - CNT_ONE;
               end
            end
         end

         assign table_pred = cnt[id_idx][CNT_W-1];
      end else begin : g_sta
         // backward branches (negative offset) predicted taken
         assign table_pred = bus.imm_sb_type_i[31];
      end
   endgenerate

   assign bus.bch_prediction_id_o = bus.id_bch_i & table_pred;

   // EX tracking register: flush wins, then a new load, then retirement on resolve
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_pred  <= 1'b0;
         ex_idx   <= '0;
      end else if (bus.ex_flush_i) begin
         ex_valid <= 1'b0;
      end else if (bus.id_ex_hs_i) begin
         ex_valid <= bus.id_bch_i;
         ex_pred  <= bus.bch_prediction_id_o;
         ex_idx   <= id_idx;
      end else if (bus.ex_resolve_i) begin
         ex_valid <= 1'b0;
      end
   end

   assign bus.ex_pred_valid_o = ex_valid;
   assign bus.ex_pred_taken_o = ex_pred;
   assign bus.ex_mispredict_o = bus.ex_resolve_i & ex_valid & (bus.ex_taken_i != ex_pred);

endmodule

// File: doc/cv32e40x_bch_predictor.md
# cv32e40x_bch_predictor

Parametrised branch/jump target unit with a dynamic branch predictor, sitting in the ID stage. It computes the JAL/branch/JALR target in ID and predicts conditional branches from a PC-indexed table of saturating counters, falling back to a static backward-taken/forward-not-taken (BTFN) rule when built in static mode. It carries each branch's prediction into EX and flags a mispredict when EX resolves the branch. On resolution it trains the counter table.

## Interface
Parameters:
- BHT_DEPTH, 16: number of counter entries; power of 2, range 2..256; IDX_W = log2(BHT_DEPTH).
- CNT_W, 2: counter width in bits; range 1..4.
- PRED_MODE, 1: 0 = static BTFN with no table; 1 = dynamic counter table.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- bch_jmp_mux_sel_i  in  bch_jmp_mux_e  CT_JAL / CT_BCH / CT_JALR.
- pc_id_i  in  32  PC of the instruction in ID.
- imm_uj_type_i, imm_sb_type_i, imm_i_type_i  in  32 each  sign-extended immediates.
- jalr_fw_i  in  32  forwarded rs1 for JALR.
- id_bch_i  in  1  ID holds a valid conditional branch.
- id_ex_hs_i  in  1  ID→EX handshake: ID valid and EX ready this cycle.
- ex_flush_i  in  1  kill the instruction entering or sitting in EX.
- ex_resolve_i  in  1  EX resolves the tracked branch this cycle.
- ex_taken_i  in  1  actual outcome; qualified by ex_resolve_i.
- bch_target_o, jmp_target_o  out  32  computed target.
- bch_prediction_id_o  out  1  predicted taken for the branch in ID.
- ex_pred_valid_o  out  1  EX holds a tracked branch.
- ex_pred_taken_o  out  1  stored prediction of that branch.
- ex_mispredict_o  out  1  ex_resolve_i & ex_pred_valid_o & (ex_taken_i != ex_pred_taken_o).

## Operation
Target computation is combinational. Both target outputs carry the same value:
- CT_JAL: pc_id_i + imm_uj_type_i.
- CT_BCH: pc_id_i + imm_sb_type_i.
- CT_JALR and default: jalr_fw_i + imm_i_type_i.
- All adds are 32-bit modulo 2^32; wrap-around is not flagged.

Prediction:
- Index is pc_id_i[IDX_W:1], so compressed instructions are indexed at halfword granularity.
- PRED_MODE=1: bch_prediction_id_o = id_bch_i & counter[idx][CNT_W-1].
- PRED_MODE=0: bch_prediction_id_o = id_bch_i & imm_sb_type_i[31]. No table is instantiated, and training inputs are ignored apart from the EX tracking register.
- When id_bch_i=0, bch_prediction_id_o=0.

EX tracking register holds valid, pred and idx:
- It is loaded on id_ex_hs_i with valid=id_bch_i, pred=bch_prediction_id_o and idx=ID index.
- It is cleared to valid=0 on ex_resolve_i, unless it is reloaded in the same cycle.
- ex_flush_i has priority over everything and forces valid=0 at the next edge.
- If ex_resolve_i arrives while valid=0, it is ignored: no mispredict and no training.

Training happens at the clock edge when ex_resolve_i & ex_pred_valid_o & !ex_flush_i:
- counter[idx] saturates: taken increments up to 2^CNT_W-1; not-taken decrements down to 0.

Same-index collision:
- If ID reads and EX writes the same entry in one cycle, ID sees the old value. There is no bypass.

## Timing
- Reset values:
  - Every counter resets to 2^(CNT_W-1)-1 (weakly not-taken; 0 when CNT_W=1).
  - EX register resets to valid=0, pred=0, idx=0.
  - ex_pred_valid_o, ex_pred_taken_o and ex_mispredict_o are 0 in reset.
  - Target outputs and bch_prediction_id_o remain combinational from inputs and reset state.
- Latency:
  - Targets and prediction are valid in the same cycle as ID.
  - The stored prediction appears on the EX outputs one cycle after id_ex_hs_i.
  - ex_mispredict_o is combinational in the resolve cycle.
  - A trained counter is visible to ID one cycle after resolve.
- Simultaneous resolve and handshake: the current branch trains and its outcome is reported, and the new branch is loaded at the same edge.
- Reset asserted mid-operation clears the table and EX register immediately (asynchronous). Operation resumes on the first edge after rst_n deasserts.

## Test plan
- Targets: pc=0x0000_1000 with imm_uj=0x0000_0800 → 0x0000_1800. CT_BCH with imm_sb=0xFFFF_FFF0 → 0x0000_0FF0. CT_JALR with jalr_fw=0xFFFF_FFFC and imm_i=8 → 0x0000_0004 (wrap).
- Reset: after rst_n release, a branch at pc=0x100 predicts 0, and ex_pred_valid_o=0.
- Training (CNT_W=2): resolve taken twice at pc=0x100 → next lookup predicts 1. Four further taken resolves leave counter=3. Two not-taken resolves → predicts 0.
- Mispredict: branch predicted 0 enters EX and resolves with taken=1 → ex_mispredict_o=1 for one cycle. A concurrent ex_flush_i in an earlier cycle kills it → no mispredict and counter unchanged.
- Collision: resolve taken at idx 5 while ID looks up idx 5 with counter=1 → ID sees 0 this cycle and 1 the next cycle.
- PRED_MODE=0: imm_sb=0xFFFF_FFF8 → prediction 1; imm_sb=0x0000_0010 → prediction 0, regardless of prior training.
